phy_rx_deframer: RTL
====================

PHY_RX_DEFRAMER -- requirements
Module: phy_rx_deframer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: bit-rate clock; all logic samples on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-003 The block SHALL have port data_in, input, 1 bit: serial stream, MSB of each byte first.
REQ-004 The block SHALL have ports Out0, Out1, Out2, Out3, each output, 8 bits: received lane bytes.
REQ-005 The block SHALL have ports valid0, valid1, valid2, valid3, each output, 1 bit: per-lane valid for Out0..Out3.
REQ-006 The block SHALL have port active, output, 1 bit: high while the FSM is in ACTIVE.
REQ-007 The block SHALL use parameter COM with default 8'hBC: comma/idle symbol.
REQ-008 The block SHALL use parameter LOCK_COUNT with default 4: consecutive aligned COM bytes required to lock.

Function
REQ-009 Every cycle, the block SHALL form candidate = {shift[6:0], data_in} and then shift data_in into the 8-bit shift register.
REQ-010 The FSM SHALL have exactly three states: SEARCH, ALIGN and ACTIVE.
REQ-011 In SEARCH, the block SHALL compare candidate with COM on every bit; on a match it SHALL go to ALIGN with bit_cnt=0 and com_cnt=1.
REQ-012 In ALIGN, bit_cnt SHALL count 0..7 and wrap; the candidate SHALL be checked only at the edge where bit_cnt==7.
REQ-013 In ALIGN, when candidate==COM, com_cnt SHALL increment; when com_cnt reaches LOCK_COUNT, the FSM SHALL go to ACTIVE with lane=0.
REQ-014 In ALIGN, when candidate!=COM at a byte boundary, the FSM SHALL return to SEARCH with com_cnt=0; that byte SHALL NOT be re-checked as a bit-level match.
REQ-015 In ACTIVE, bit_cnt SHALL free-run mod 8 and the 2-bit lane counter SHALL increment mod 4 at each byte boundary.
REQ-016 At each byte boundary in ACTIVE, the block SHALL capture the byte for the current lane as a pending lane register: COM gives valid=0 and data=8'h00; any other value gives valid=1 and data=candidate.
REQ-017 At the byte boundary of lane 3, the block SHALL load Out0..Out3 and valid0..3 on that same edge, from pending lanes 0-2 plus the live lane-3 byte; there SHALL be no extra latency.
REQ-018 Out0..Out3 and valid0..3 SHALL hold their values between frame updates; a frame therefore updates every 32 clocks.
REQ-019 The block SHALL never leave ACTIVE except through reset; all-COM frames SHALL be legal and produce all valids at 0.
REQ-020 active SHALL be registered and SHALL assert on the edge where the FSM enters ACTIVE.

Reset
REQ-021 While reset==0 at a rising clk edge, the block SHALL set: state=SEARCH, shift=0, bit_cnt=0, com_cnt=0, lane=0, all pending registers=0, Out0..3=8'h00, valid0..3=0, active=0.
REQ-022 Reset asserted mid-frame SHALL discard partial lanes; no output update SHALL occur from that frame.
REQ-023 After reset release, the first bit sampled SHALL be treated as bit 7 (MSB) of the search window.

Structure
REQ-024 The shared package phy_pkg SHALL hold COM_SYM=8'hBC, LOCK_COUNT, the FSM state typedef (SEARCH/ALIGN/ACTIVE) and lane-index width.
REQ-025 The shift register, bit_cnt and COM comparator SHALL live in one sub-module, rx_shift_aligner (outputs: candidate, byte_strobe, com_hit); lane demux and the FSM SHALL stay in the top.

Verification
REQ-026 Scenario: reset low for 3 clocks, data_in=1 -> all outputs 0, active=0, state stays SEARCH.
REQ-027 Scenario: 4 x 10111100 then frame FF,EE,DD,CC -> active rises at the 32nd bit; Out0..3=FF,EE,DD,CC and valid0..3=1111 on the edge of the frame's 32nd bit.
REQ-028 Scenario: 3 random bits, then 4 x BC, then frame BB,AA,99,88 -> bit-level lock succeeds; outputs BB,AA,99,88 with all valids 1.
REQ-029 Scenario: after lock, frame BC,BC,77,BC -> Out=00,00,77,00 and valid0..3=0,0,1,0.
REQ-030 Scenario: BC,BC,BC,55 in ALIGN -> FSM returns to SEARCH, active stays 0; a following 4 x BC then locks.
REQ-031 Scenario: reset pulsed low after lane-1 byte of an ACTIVE frame -> no output update; outputs 0 and relock is required.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared types and constants for the serial RX deframer.
// Comma symbol, lock depth, FSM states and lane helpers.
package phy_pkg;

    localparam logic [7:0] COM_SYM    = 8'hBC;
    localparam int         LOCK_COUNT = 4;
    localparam int         LANE_W     = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_e;

    typedef logic [LANE_W-1:0] lane_idx_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } lane_byte_t;

    // A comma in a lane slot means "no data": valid low, data zeroed.
    function automatic lane_byte_t lane_byte(input logic       is_com,
                                             input logic [7:0] b);
        lane_byte_t r;
        r.valid = !is_com;
        r.data  = is_com ? 8'h00 : b;
        return r;
    endfunction

endpackage

// File: rtl/rx_shift_aligner.sv
// Bit shifter, byte phase counter and comma comparator.
// The candidate includes the bit arriving this cycle.
module rx_shift_aligner
    import phy_pkg::*;
#(
    parameter logic [7:0] COM = COM_SYM
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    input  logic       clr,
    output logic [7:0] candidate,
    output logic       byte_strobe,
    output logic       com_hit
);

    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;

    assign candidate   = {shift_q[6:0], data_in};
    assign com_hit     = (candidate == COM);
    assign byte_strobe = (bit_cnt_q == 3'd7);

    // Shift the serial stream in, MSB first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q <= 8'h00;
        end else begin
            shift_q <= candidate;
        end
    end

    // Byte phase: held at 0 while searching, free-runs mod 8 otherwise.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            bit_cnt_q <= 3'd0;
        end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
        end
    end

endmodule

// File: rtl/phy_rx_deframer.sv
// Comma-aligned serial deframer: locks on repeated commas,
// then demuxes bytes into four lanes updated once per frame.
module phy_rx_deframer
    import phy_pkg::*;
#(
    parameter logic [7:0] COM        = COM_SYM,
    parameter int         LOCK_COUNT = phy_pkg::LOCK_COUNT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] Out0,
    output logic [7:0] Out1,
    output logic [7:0] Out2,
    output logic [7:0] Out3,
    output logic       valid0,
    output logic       valid1,
    output logic       valid2,
    output logic       valid3,
    output logic       active
);

    localparam int CW = $clog2(LOCK_COUNT + 1);

    rx_state_e  state_q;
    logic [CW-1:0] com_cnt_q;
    logic [CW-1:0] com_nxt;
    lane_idx_t  lane_q;
    lane_byte_t pend0_q;
    lane_byte_t pend1_q;
    lane_byte_t pend2_q;
    lane_byte_t cur;

    logic [7:0] candidate;
    logic       byte_strobe;
    logic       com_hit;

    rx_shift_aligner #(
        .COM (COM)
    ) u_aligner (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .clr         (state_q == SEARCH),
        .candidate   (candidate),
        .byte_strobe (byte_strobe),
        .com_hit     (com_hit)
    );

    assign com_nxt = com_cnt_q + 1'b1;
    assign cur     = lane_byte(com_hit, candidate);

    // Lock FSM, lane demux and registered frame outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= SEARCH;
            com_cnt_q <= '0;
            lane_q    <= '0;
            pend0_q   <= '0;
            pend1_q   <= '0;
            pend2_q   <= '0;
            Out0      <= 8'h00;
            Out1      <= 8'h00;
            Out2      <= 8'h00;
            Out3      <= 8'h00;
            valid0    <= 1'b0;
            valid1    <= 1'b0;
            valid2    <= 1'b0;
            valid3    <= 1'b0;
            active    <= 1'b0;
        end else begin
            unique case (state_q)
                SEARCH: begin
                    if (com_hit) begin
                        state_q   <= ALIGN;
                        com_cnt_q <= CW'(1);
                    end
                end
                ALIGN: begin
                    if (byte_strobe) begin
                        if (com_hit) begin
                            com_cnt_q <= com_nxt;
                            if (com_nxt == CW'(LOCK_COUNT)) begin
                                state_q <= ACTIVE;
                                active  <= 1'b1;
                                lane_q  <= '0;
                            end
                        end else begin
                            state_q   <= SEARCH;
                            com_cnt_q <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (byte_strobe) begin
                        lane_q <= lane_q + 1'b1;
                        unique case (lane_q)
                            2'd0: pend0_q <= cur;
                            2'd1: pend1_q <= cur;
                            2'd2: pend2_q <= cur;
                            2'd3: begin
                                Out0   <= pend0_q.data;
                                Out1   <= pend1_q.data;
                                Out2   <= pend2_q.data;
                                Out3   <= cur.data;
                                valid0 <= pend0_q.valid;
                                valid1 <= pend1_q.valid;
                                valid2 <= pend2_q.valid;
                                valid3 <= cur.valid;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

endmodule
